// File: rtl/ring8_phase_monitor_if.sv
// Bundle between the 8-stage ring-counter phase monitor and its consumers
// (TDM slot logic and status block).
interface ring8_phase_monitor_if #(
   parameter int REV_WIDTH = 16
);
   logic [7:0]           PHASE;
   logic                 ERR_CLR;
   logic [2:0]           SLOT;
   logic                 SLOT_VALID;
   logic                 WRAP;
   logic [REV_WIDTH-1:0] REVS;
   logic                 ERR;
   logic [1:0]           ERR_CODE;

   modport master (
      output PHASE, ERR_CLR,
      input  SLOT, SLOT_VALID, WRAP, REVS, ERR, ERR_CODE
   );

   modport slave (
      input  PHASE, ERR_CLR,
      output SLOT, SLOT_VALID, WRAP, REVS, ERR, ERR_CODE
   );
endinterface

// File: rtl/ring8_phase_monitor.sv
// Locks onto a one-hot ring-counter phase, encodes the slot, counts revolutions and
// flags ring corruption. Define RING8_MON_STALL_TOL_EN to accept a held ring in LOCK.
module ring8_phase_monitor #(
   parameter int REV_WIDTH    = 16,
   parameter int SYNC_TIMEOUT = 16
) (
   input logic CLK,
   input logic RESET,
   ring8_phase_monitor_if.slave mon
);

   typedef enum logic {SYNC, LOCK} state_t;

   localparam logic [1:0] CODE_ZERO  = 2'b01;
   localparam logic [1:0] CODE_MULTI = 2'b10;
   localparam logic [1:0] CODE_SEQ   = 2'b11;

   function automatic logic [3:0] popCount(input logic [7:0] p);
      logic [3:0] c;
      c = 4'd0;
      for (int i = 0; i < 8; i++) c = c + {3'b000, p[i]};
      return c;
   endfunction

   function automatic logic [2:0] slotIndex(input logic [7:0] p);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 8; i++) if (p[i]) idx = 3'(i);
      return idx;
   endfunction

   function automatic logic [7:0] satInc(input logic [7:0] t);
      return (t == 8'hFF) ? t : t + 8'd1;
   endfunction

   state_t               state_p1;
   logic [7:0]           lastQ_p1;
   logic [7:0]           tcnt_p1;
   logic [2:0]           slot_p1;
   logic                 slotValid_p1;
   logic                 wrap_p1;
   logic [REV_WIDTH-1:0] revs_p1;
   logic                 err_p1;
   logic [1:0]           errCode_p1;

   logic       isZero, isMulti, isOneHot, stallOk;
   logic [7:0] expected;
   logic       errFlag;
   logic [1:0] newCode;

   assign isZero   = (mon.PHASE == 8'h00);
   assign isMulti  = (popCount(mon.PHASE) > 4'd1);
   assign isOneHot = !isZero && !isMulti;
   assign expected = {lastQ_p1[6:0], lastQ_p1[7]};

`ifdef RING8_MON_STALL_TOL_EN
   assign stallOk = (mon.PHASE == lastQ_p1);
`else
   assign stallOk = 1'b0;
`endif

   always_comb begin
      errFlag = 1'b0;
      newCode = 2'b00;
      case (state_p1)
         SYNC: begin
            // Illegal samples in SYNC only count toward the timeout.
            if (!isOneHot && (satInc(tcnt_p1) == 8'(SYNC_TIMEOUT))) begin
               errFlag = 1'b1;
               newCode = isZero ? CODE_ZERO : CODE_MULTI;
            end
         end
         LOCK: begin
            if (isZero) begin
               errFlag = 1'b1;
               newCode = CODE_ZERO;
            end else if (isMulti) begin
               errFlag = 1'b1;
               newCode = CODE_MULTI;
            end else if ((mon.PHASE != expected) && !stallOk) begin
               errFlag = 1'b1;
               newCode = CODE_SEQ;
            end
         end
         default: ;
      endcase
   end

   // Registered stage: FSM, slot/revolution tracking and sticky error.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_p1     <= SYNC;
         lastQ_p1     <= 8'h00;
         tcnt_p1      <= 8'h00;
         slot_p1      <= 3'd0;
         slotValid_p1 <= 1'b0;
         wrap_p1      <= 1'b0;
         revs_p1      <= '0;
         err_p1       <= 1'b0;
         errCode_p1   <= 2'b00;
      end else begin
         wrap_p1 <= 1'b0;
         case (state_p1)
            SYNC: begin
               if (isOneHot) begin
                  state_p1     <= LOCK;
                  slot_p1      <= slotIndex(mon.PHASE);
                  slotValid_p1 <= 1'b1;
                  lastQ_p1     <= mon.PHASE;
                  tcnt_p1      <= 8'h00;
               end else begin
                  tcnt_p1 <= errFlag ? 8'h00 : satInc(tcnt_p1);
               end
            end
            LOCK: begin
               if (errFlag) begin
                  state_p1     <= SYNC;
                  slotValid_p1 <= 1'b0;
                  tcnt_p1      <= 8'h00;
               end else if (mon.PHASE == expected) begin
                  slot_p1  <= slotIndex(mon.PHASE);
                  lastQ_p1 <= mon.PHASE;
                  if (lastQ_p1 == 8'h80) begin
                     wrap_p1 <= 1'b1;
                     revs_p1 <= revs_p1 + 1'b1;
                  end
               end
            end
            default: state_p1 <= SYNC;
         endcase

         // A fresh error beats a simultaneous clear; otherwise the first code is kept.
         if (errFlag) begin
            err_p1 <= 1'b1;
            if (!err_p1 || mon.ERR_CLR) errCode_p1 <= newCode;
         end else if (mon.ERR_CLR) begin
            err_p1     <= 1'b0;
            errCode_p1 <= 2'b00;
         end
      end
   end

   assign mon.SLOT       = slot_p1;
   assign mon.SLOT_VALID = slotValid_p1;
   assign mon.WRAP       = wrap_p1;
   assign mon.REVS       = revs_p1;
   assign mon.ERR        = err_p1;
   assign mon.ERR_CODE   = errCode_p1;

endmodule

// File: tb/tb_ring8_phase_monitor.sv
// Directed bench for ring8_phase_monitor (REV_WIDTH=2 to exercise REVS rollover).
module tb_ring8_phase_monitor;

   logic CLK;
   logic RESET;
   int   nCompared;
   int   nMismatched;

   ring8_phase_monitor_if #(.REV_WIDTH(2)) bus ();

   ring8_phase_monitor #(.REV_WIDTH(2), .SYNC_TIMEOUT(16)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .mon   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input int obs, input int exp);
      nCompared++;
      if (obs !== exp) begin
         nMismatched++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [7:0] p);
      bus.PHASE = p;
      @(posedge CLK);
      #1;
   endtask

   task automatic chkAllZero(input string tag);
      chk({tag, ".slot"},  32'(bus.SLOT), 0);
      chk({tag, ".valid"}, 32'(bus.SLOT_VALID), 0);
      chk({tag, ".wrap"},  32'(bus.WRAP), 0);
      chk({tag, ".revs"},  32'(bus.REVS), 0);
      chk({tag, ".err"},   32'(bus.ERR), 0);
      chk({tag, ".code"},  32'(bus.ERR_CODE), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      nCompared   = 0;
      nMismatched = 0;
      RESET       = 1'b1;
      bus.PHASE   = 8'h00;
      bus.ERR_CLR = 1'b0;

      // Reset state
      step(8'h00);
      step(8'h01);
      chkAllZero("rst");
      RESET = 1'b0;

      // Full revolution with lock on first sample
      for (int i = 0; i < 8; i++) begin
         step(8'(1 << i));
         chk($sformatf("rev.slot%0d", i), 32'(bus.SLOT), i);
         chk($sformatf("rev.valid%0d", i), 32'(bus.SLOT_VALID), 1);
         chk($sformatf("rev.wrap%0d", i), 32'(bus.WRAP), 0);
      end
      step(8'h01);
      chk("wrap.slot", 32'(bus.SLOT), 0);
      chk("wrap.pulse", 32'(bus.WRAP), 1);
      chk("wrap.revs", 32'(bus.REVS), 1);
      chk("wrap.err", 32'(bus.ERR), 0);
      step(8'h02);
      chk("wrap.end", 32'(bus.WRAP), 0);

      // Skip error, then relock
      step(8'h04);
      chk("skip.pre", 32'(bus.SLOT), 2);
      step(8'h10);
      chk("skip.err", 32'(bus.ERR), 1);
      chk("skip.code", 32'(bus.ERR_CODE), 3);
      chk("skip.valid", 32'(bus.SLOT_VALID), 0);
      chk("skip.slot", 32'(bus.SLOT), 2);
      step(8'h20);
      chk("relock.valid", 32'(bus.SLOT_VALID), 1);
      chk("relock.slot", 32'(bus.SLOT), 5);
      chk("relock.err", 32'(bus.ERR), 1);
      chk("relock.code", 32'(bus.ERR_CODE), 3);

      // Clear alone
      bus.ERR_CLR = 1'b1;
      step(8'h40);
      bus.ERR_CLR = 1'b0;
      chk("clr.err", 32'(bus.ERR), 0);
      chk("clr.code", 32'(bus.ERR_CODE), 0);
      chk("clr.slot", 32'(bus.SLOT), 6);

      // Zero then multi: first code kept
      step(8'h00);
      chk("zero.err", 32'(bus.ERR), 1);
      chk("zero.code", 32'(bus.ERR_CODE), 1);
      chk("zero.valid", 32'(bus.SLOT_VALID), 0);
      step(8'h03);
      chk("multi.code", 32'(bus.ERR_CODE), 1);
      bus.ERR_CLR = 1'b1;
      step(8'h01);
      chk("clr2.err", 32'(bus.ERR), 0);
      chk("clr2.code", 32'(bus.ERR_CODE), 0);
      chk("clr2.valid", 32'(bus.SLOT_VALID), 1);
      chk("clr2.wrap", 32'(bus.WRAP), 0);
      // Error with clear in the same cycle: new error wins
      step(8'h08);
      bus.ERR_CLR = 1'b0;
      chk("clrerr.err", 32'(bus.ERR), 1);
      chk("clrerr.code", 32'(bus.ERR_CODE), 3);
      step(8'h01);
      chk("lock3.valid", 32'(bus.SLOT_VALID), 1);
      step(8'h00);
      chk("keep.code", 32'(bus.ERR_CODE), 3);
      chk("keep.valid", 32'(bus.SLOT_VALID), 0);

      // SYNC timeout on zero, then on multi-hot
      RESET = 1'b1;
      step(8'h00);
      RESET = 1'b0;
      for (int i = 0; i < 15; i++) step(8'h00);
      chk("to15.err", 32'(bus.ERR), 0);
      step(8'h00);
      chk("to16.err", 32'(bus.ERR), 1);
      chk("to16.code", 32'(bus.ERR_CODE), 1);
      chk("to16.valid", 32'(bus.SLOT_VALID), 0);
      bus.ERR_CLR = 1'b1;
      step(8'h03);
      bus.ERR_CLR = 1'b0;
      chk("tom.clr", 32'(bus.ERR), 0);
      for (int i = 0; i < 14; i++) step(8'h03);
      chk("tom15.err", 32'(bus.ERR), 0);
      step(8'h03);
      chk("tom16.err", 32'(bus.ERR), 1);
      chk("tom16.code", 32'(bus.ERR_CODE), 2);

      // Stalled ring
      bus.ERR_CLR = 1'b1;
      step(8'h01);
      bus.ERR_CLR = 1'b0;
      step(8'h02);
      step(8'h04);
      step(8'h08);
      chk("stall.pre", 32'(bus.SLOT), 3);
      chk("stall.preerr", 32'(bus.ERR), 0);
      step(8'h08);
      chk("stall.slot", 32'(bus.SLOT), 3);
`ifdef RING8_MON_STALL_TOL_EN
      chk("stall.err", 32'(bus.ERR), 0);
      chk("stall.valid", 32'(bus.SLOT_VALID), 1);
      step(8'h10);
      chk("stall.resume", 32'(bus.SLOT), 4);
      chk("stall.resumeerr", 32'(bus.ERR), 0);
`else
      chk("stall.err", 32'(bus.ERR), 1);
      chk("stall.code", 32'(bus.ERR_CODE), 3);
      chk("stall.valid", 32'(bus.SLOT_VALID), 0);
`endif

      // REVS rollover with 2-bit counter
      RESET = 1'b1;
      step(8'h00);
      RESET = 1'b0;
      step(8'h01);
      chk("rv.lock", 32'(bus.SLOT_VALID), 1);
      chk("rv.revs0", 32'(bus.REVS), 0);
      for (int r = 1; r <= 5; r++) begin
         for (int i = 1; i < 8; i++) step(8'(1 << i));
         chk($sformatf("rv.nowrap%0d", r), 32'(bus.WRAP), 0);
         step(8'h01);
         chk($sformatf("rv.wrap%0d", r), 32'(bus.WRAP), 1);
         chk($sformatf("rv.revs%0d", r), 32'(bus.REVS), r % 4);
      end
      step(8'h02);
      chk("rv.wrapend", 32'(bus.WRAP), 0);
      step(8'h04);

      // Reset mid-LOCK, then relock
      RESET = 1'b1;
      step(8'h08);
      chkAllZero("midrst");
      RESET = 1'b0;
      step(8'h10);
      chk("post.valid", 32'(bus.SLOT_VALID), 1);
      chk("post.slot", 32'(bus.SLOT), 4);
      chk("post.revs", 32'(bus.REVS), 0);
      chk("post.err", 32'(bus.ERR), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
